// File: rtl/dtw_query_scheduler_if.sv
// Handshake bundle between the query scheduler, the shared source/sink FIFOs and the dtw_core array.
// master = scheduler side, slave = FIFO/core side.
interface dtw_query_scheduler_if #(
    parameter int NUM_CORES = 4
);
    logic                   enable;
    logic                   src_fifo_empty;
    logic                   src_fifo_rden;
    logic [NUM_CORES-1:0]   core_load_done;
    logic [NUM_CORES-1:0]   core_busy;
    logic [NUM_CORES-1:0]   core_rs;
    logic [NUM_CORES-1:0]   core_src_rden;
    logic [NUM_CORES-1:0]   core_src_empty;
    logic [NUM_CORES-1:0]   core_res_req;
    logic [NUM_CORES-1:0]   core_sink_wren;
    logic [32*NUM_CORES-1:0] core_sink_data;
    logic [NUM_CORES-1:0]   core_sink_last;
    logic [NUM_CORES-1:0]   core_sink_full;
    logic                   sink_fifo_full;
    logic                   sink_fifo_wren;
    logic [31:0]            sink_fifo_data;
    logic                   sink_fifo_last;
    logic                   sched_busy;

    modport master (
        input  enable, src_fifo_empty, core_load_done, core_busy, core_src_rden,
               core_res_req, core_sink_wren, core_sink_data, core_sink_last, sink_fifo_full,
        output src_fifo_rden, core_rs, core_src_empty, core_sink_full,
               sink_fifo_wren, sink_fifo_data, sink_fifo_last, sched_busy
    );

    modport slave (
        output enable, src_fifo_empty, core_load_done, core_busy, core_src_rden,
               core_res_req, core_sink_wren, core_sink_data, core_sink_last, sink_fifo_full,
        input  src_fifo_rden, core_rs, core_src_empty, core_sink_full,
               sink_fifo_wren, sink_fifo_data, sink_fifo_last, sched_busy
    );
endinterface

// File: rtl/dtw_query_scheduler.sv
// Round-robin query dispatch to idle dtw_cores (rs 1 cycle after data+idle core) and fixed-priority result merge
// (first word 2 cycles after res_req); sink full stalls only the granted core. SCHED_PERF_CNT_EN adds perf counters.
module dtw_query_scheduler #(
    parameter int NUM_CORES = 4,
    parameter int SQG_SIZE  = 250,
    parameter int CID_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    dtw_query_scheduler_if.master io
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]           perf_dispatched,
    output logic [31:0]           perf_completed
`endif
);
    localparam int RCNT_W = $clog2(SQG_SIZE + 2);

    typedef enum logic [1:0] {D_IDLE, D_START, D_WAIT, D_STREAM} dstate_t;
    typedef enum logic {R_IDLE, R_GRANT} rstate_t;

    dstate_t              dstate;
    rstate_t              rstate;
    logic [CID_WIDTH-1:0] dgrant, rr_ptr, rgrant, pick, rlow;
    logic [RCNT_W-1:0]    rcnt;
    logic [NUM_CORES-1:0] idle, pick_oh;
    logic                 found, g_busy, g_rden, r_wren, r_last, r_req;
    logic [31:0]          r_data;
    logic                 stream_done;

    assign idle = io.core_load_done & ~io.core_busy;

    // First idle core at or after rr_ptr, wrapping around the core array.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            int c;
            c = int'(rr_ptr) + k;
            if (c >= NUM_CORES) c = c - NUM_CORES;
            if (!found && idle[c]) begin
                found   = 1'b1;
                pick    = CID_WIDTH'(c);
                pick_oh = NUM_CORES'(1) << c;
            end
        end
    end

    always_comb begin
        rlow = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (io.core_res_req[i]) rlow = CID_WIDTH'(i);
        end
    end

    always_comb begin
        g_busy = 1'b0;
        g_rden = 1'b0;
        r_wren = 1'b0;
        r_last = 1'b0;
        r_req  = 1'b0;
        r_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (dgrant == CID_WIDTH'(i)) begin
                g_busy = io.core_busy[i];
                g_rden = io.core_src_rden[i];
            end
            if (rgrant == CID_WIDTH'(i)) begin
                r_wren = io.core_sink_wren[i];
                r_last = io.core_sink_last[i];
                r_req  = io.core_res_req[i];
                r_data = io.core_sink_data[32*i +: 32];
            end
        end
    end

    // The qid word plus SQG_SIZE samples: leave on the read that brings the count to SQG_SIZE+1.
    assign stream_done = (dstate == D_STREAM) && g_rden && !io.src_fifo_empty &&
                         (rcnt == RCNT_W'(SQG_SIZE));

    always_ff @(posedge clk) begin
        if (rst) begin
            dstate     <= D_IDLE;
            dgrant     <= '0;
            rr_ptr     <= '0;
            rcnt       <= '0;
            io.core_rs <= '0;
        end else begin
            io.core_rs <= '0;
            case (dstate)
                D_IDLE: begin
                    if (io.enable && !io.src_fifo_empty && found) begin
                        dgrant     <= pick;
                        io.core_rs <= pick_oh;
                        dstate     <= D_START;
                    end
                end
                D_START: dstate <= D_WAIT;
                D_WAIT: begin
                    if (g_busy) dstate <= D_STREAM;
                end
                D_STREAM: begin
                    if (stream_done) begin
                        rcnt   <= '0;
                        rr_ptr <= (dgrant == CID_WIDTH'(NUM_CORES - 1)) ? '0 : dgrant + CID_WIDTH'(1);
                        dstate <= D_IDLE;
                    end else if (g_rden && !io.src_fifo_empty) begin
                        rcnt <= rcnt + RCNT_W'(1);
                    end
                end
                default: dstate <= D_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rstate <= R_IDLE;
            rgrant <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (|io.core_res_req) begin
                        rgrant <= rlow;
                        rstate <= R_GRANT;
                    end
                end
                R_GRANT: begin
                    if (r_last || !r_req) rstate <= R_IDLE;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        io.src_fifo_rden  = (dstate == D_STREAM) && g_rden;
        io.core_src_empty = '1;
        io.core_sink_full = '1;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (dstate == D_STREAM && dgrant == CID_WIDTH'(i)) io.core_src_empty[i] = io.src_fifo_empty;
            if (rstate == R_GRANT && rgrant == CID_WIDTH'(i)) io.core_sink_full[i] = io.sink_fifo_full;
        end
        io.sink_fifo_wren = (rstate == R_GRANT) && r_wren;
        io.sink_fifo_last = (rstate == R_GRANT) && r_last;
        io.sink_fifo_data = (rstate == R_GRANT) ? r_data : 32'd0;
    end

    assign io.sched_busy = (dstate != D_IDLE) || (|io.core_busy);

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_dispatched <= '0;
            perf_completed  <= '0;
        end else begin
            if (stream_done) perf_dispatched <= perf_dispatched + 32'd1;
            if (rstate == R_GRANT && r_last) perf_completed <= perf_completed + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dtw_query_scheduler.sv
// Directed bench for dtw_query_scheduler: behavioural FIFO and dtw_core models around the DUT.
module tb_dtw_query_scheduler;
    localparam int NC  = 4;
    localparam int SQG = 250;
    localparam int QW  = SQG + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dtw_query_scheduler_if #(.NUM_CORES(NC)) io ();

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_d, perf_c;
`endif

    dtw_query_scheduler #(.NUM_CORES(NC), .SQG_SIZE(SQG), .CID_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_dispatched (perf_d),
        .perf_completed  (perf_c)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [NC-1:0]    m_busy, m_reading, man_busy, res_pend, res_go, c_wren, c_last;
    logic [32*NC-1:0] c_data;
    int               reads [NC];
    int               qreads[NC];
    int               rword [NC];
    int               src_words, load_val;
    logic             load_go, stall;
    logic [31:0]      sink_q[$];
    logic             last_q[$];
    int               rs_q[$];
    int               c1_viol = 0, full3_viol = 0;
    logic             mon_c1 = 1'b0;

    function automatic logic [31:0] exp_word(int c, int k);
        return 32'hD000_0000 | 32'(c * 256) | 32'(k);
    endfunction

    assign io.src_fifo_empty = (src_words == 0) || stall;
    assign io.core_busy      = m_busy | man_busy;
    assign io.core_src_rden  = m_reading & ~io.core_src_empty;
    assign io.core_res_req   = res_pend;
    assign io.core_sink_wren = c_wren;
    assign io.core_sink_last = c_last;
    assign io.core_sink_data = c_data;

    always_comb begin
        c_wren = '0;
        c_last = '0;
        c_data = '0;
        for (int i = 0; i < NC; i++) begin
            c_wren[i] = res_pend[i] && !io.core_sink_full[i];
            c_last[i] = c_wren[i] && (rword[i] == 2);
            c_data[32*i +: 32] = exp_word(i, rword[i]);
        end
    end

    // Core and FIFO models: a started core goes busy, reads one query, then goes idle.
    always @(posedge clk) begin
        if (rst) begin
            m_busy    <= '0;
            m_reading <= '0;
            res_pend  <= '0;
            src_words <= 0;
            for (int i = 0; i < NC; i++) begin
                reads[i]  <= 0;
                qreads[i] <= 0;
                rword[i]  <= 0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                if (io.core_rs[i]) begin
                    m_busy[i]    <= 1'b1;
                    m_reading[i] <= 1'b1;
                    qreads[i]    <= 0;
                end else if (io.core_src_rden[i]) begin
                    reads[i]  <= reads[i] + 1;
                    qreads[i] <= qreads[i] + 1;
                    if (qreads[i] == QW - 1) begin
                        m_reading[i] <= 1'b0;
                        m_busy[i]    <= 1'b0;
                    end
                end
                if (res_go[i]) begin
                    res_pend[i] <= 1'b1;
                    rword[i]    <= 0;
                end else if (c_wren[i]) begin
                    rword[i] <= rword[i] + 1;
                    if (rword[i] == 2) res_pend[i] <= 1'b0;
                end
            end
            if (load_go) src_words <= load_val;
            else if (io.src_fifo_rden && !io.src_fifo_empty) src_words <= src_words - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (io.sink_fifo_wren && !io.sink_fifo_full) begin
                sink_q.push_back(io.sink_fifo_data);
                last_q.push_back(io.sink_fifo_last);
            end
            for (int i = 0; i < NC; i++) if (io.core_rs[i]) rs_q.push_back(i);
            if (mon_c1 && !io.core_src_empty[1]) c1_viol <= c1_viol + 1;
            if (res_pend[0] && !io.core_sink_full[3]) full3_viol <= full3_viol + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int n);
        load_val = n;
        load_go  = 1'b1;
        tick();
        load_go  = 1'b0;
    endtask

    task automatic wait_reads(input int c, input int n, input int budget, input string tag);
        int t = 0;
        while (reads[c] < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, reads[c], n);
    endtask

    task automatic wait_q(input int n, input int budget, input string tag);
        int t = 0;
        while (sink_q.size() < n && t < budget) begin
            tick();
            t++;
        end
        check(tag, sink_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        io.enable = 1'b0;
        io.core_load_done = '0;
        io.sink_fifo_full = 1'b0;
        man_busy = '0;
        res_go = '0;
        load_go = 1'b0;
        load_val = 0;
        stall = 1'b0;
        repeat (3) tick();

        check("rst_src_rden",   io.src_fifo_rden,  0);
        check("rst_src_empty",  io.core_src_empty, 4'hF);
        check("rst_sink_full",  io.core_sink_full, 4'hF);
        check("rst_sink_wren",  io.sink_fifo_wren, 0);
        check("rst_sink_data",  io.sink_fifo_data, 0);
        check("rst_sink_last",  io.sink_fifo_last, 0);
        check("rst_core_rs",    io.core_rs,        0);
        check("rst_sched_busy", io.sched_busy,     0);
        rst = 1'b0;
        tick();

        // Data queued and enabled, but no reference loaded anywhere.
        load(2 * QW);
        io.enable = 1'b1;
        repeat (10) tick();
        check("noload_rs",   rs_q.size(), 0);
        check("noload_busy", io.sched_busy, 0);

        // Two queries, all cores loaded and idle.
        io.core_load_done = 4'hF;
        tick();
        check("t1_rs_latency", io.core_rs, 4'b0001);
        wait_reads(0, QW, 1000, "t1_c0_reads");
        wait_reads(1, QW, 1000, "t1_c1_reads");
        repeat (5) tick();
        check("t1_c0_exact", reads[0], QW);
        check("t1_c1_exact", reads[1], QW);
        check("t1_fifo_drained", src_words, 0);
        check("t1_rs_count", rs_q.size(), 2);
        check("t1_rs_order", {rs_q.size() > 0 ? rs_q[0] : 99, rs_q.size() > 1 ? rs_q[1] : 99}, {32'd0, 32'd1});

        // Third query lands on core2; reset it mid-stream.
        rs_q.delete();
        load(QW);
        wait_reads(2, 50, 400, "t6_reads50");
        check("t6_rr_core2", rs_q.size() > 0 ? rs_q[0] : 99, 2);
        rst = 1'b1;
        tick();
        check("t6_src_rden",  io.src_fifo_rden,  0);
        check("t6_src_empty", io.core_src_empty, 4'hF);
        check("t6_rcnt",      dut.rcnt,          0);
        check("t6_busy",      io.sched_busy,     0);
        rst = 1'b0;
        tick();

        // FIFO starves after word 100 for 20 cycles; enable dropped meanwhile.
        rs_q.delete();
        load(QW);
        wait_reads(0, 100, 400, "t3_reads100");
        stall = 1'b1;
        io.enable = 1'b0;
        repeat (20) tick();
        check("t3_frozen_reads", reads[0], 100);
        check("t3_frozen_rcnt",  dut.rcnt, 100);
        check("t3_still_busy",   io.sched_busy, 1);
        stall = 1'b0;
        wait_reads(0, QW, 1000, "t3_complete");
        check("t3_rs_core0", rs_q.size() > 0 ? rs_q[0] : 99, 0);
        load(QW);
        repeat (10) tick();
        check("t3_no_dispatch_disabled", rs_q.size(), 1);

        // rr_ptr=1 but core1 busy: core2 is chosen, core1 never sees data.
        man_busy = 4'b0010;
        mon_c1 = 1'b1;
        io.enable = 1'b1;
        wait_reads(2, QW, 1000, "t2_c2_reads");
        check("t2_rs_core2", rs_q.size() > 1 ? rs_q[1] : 99, 2);
        check("t2_c1_empty", c1_viol, 0);
        check("t2_c1_reads", reads[1], 0);
        mon_c1 = 1'b0;
        man_busy = '0;

        // core0 and core3 request results together.
        res_go = 4'b1001;
        tick();
        res_go = '0;
        check("t4_idle_full", io.core_sink_full, 4'hF);
        check("t4_idle_wren", io.sink_fifo_wren, 0);
        tick();
        check("t4_grant_full", io.core_sink_full, 4'b1110);
        check("t4_first_word", {io.sink_fifo_wren, io.sink_fifo_data}, {1'b1, exp_word(0, 0)});
        wait_q(6, 40, "t4_count");
        for (int k = 0; k < 6; k++) begin
            if (sink_q.size() > k)
                check($sformatf("t4_word%0d", k), {last_q[k], sink_q[k]},
                      {(k % 3) == 2, exp_word(k < 3 ? 0 : 3, k % 3)});
        end
        check("t4_core3_full", full3_viol, 0);

        // Sink full for 5 cycles while core1 holds the grant.
        sink_q.delete();
        last_q.delete();
        res_go = 4'b0010;
        tick();
        res_go = '0;
        tick();
        io.sink_fifo_full = 1'b1;
        repeat (5) tick();
        check("t5_stalled_count", sink_q.size(), 0);
        check("t5_core1_full", io.core_sink_full[1], 1);
        io.sink_fifo_full = 1'b0;
        wait_q(3, 40, "t5_count");
        repeat (5) tick();
        check("t5_no_dup", sink_q.size(), 3);
        for (int k = 0; k < 3; k++) begin
            if (sink_q.size() > k)
                check($sformatf("t5_word%0d", k), {last_q[k], sink_q[k]}, {k == 2, exp_word(1, k)});
        end

`ifdef SCHED_PERF_CNT_EN
        check("perf_dispatched", perf_d, 2);
        check("perf_completed",  perf_c, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
